// File: rtl/trig_monitor_if.sv
// +--------------------------------------------------------------------------+
// | Module      : trig_monitor_if                                            |
// | Description : Control and status bundle between a trigger-stream         |
// |               consumer and the trig_monitor block.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface trig_monitor_if #(
   parameter int GAP_W = 8,
   parameter int CNT_W = 16
);
   logic             ene;
   logic [CNT_W-1:0] ntrig;
   logic [GAP_W-1:0] gap;
   logic             trigger;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] ntrig_seen;
   logic [CNT_W-1:0] gap_err_cnt;
   logic [GAP_W-1:0] last_gap;
   logic             err;
   logic             timeout;
   logic             overrun;
   logic [GAP_W-1:0] min_gap;
   logic [GAP_W-1:0] max_gap;

   // Controller side: drives configuration and trigger line, reads status
   modport master (
      output ene, ntrig, gap, trigger,
      input  busy, done, ntrig_seen, gap_err_cnt, last_gap,
             err, timeout, overrun, min_gap, max_gap
   );

   // Monitor side
   modport slave (
      input  ene, ntrig, gap, trigger,
      output busy, done, ntrig_seen, gap_err_cnt, last_gap,
             err, timeout, overrun, min_gap, max_gap
   );
endinterface

`default_nettype wire

// File: rtl/trig_monitor.sv
// +--------------------------------------------------------------------------+
// | Module      : trig_monitor                                               |
// | Description : Counts pulses on a single-cycle trigger line against an    |
// |               expected total, measures inter-trigger intervals against   |
// |               an expected gap and reports done/err/timeout/overrun.      |
// |               Optional macro TRIG_HIST_EN builds min/max interval        |
// |               tracking; otherwise min_gap/max_gap read as zero.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module trig_monitor #(
   parameter int GAP_W   = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic          clk,
   input  logic          rst,
   trig_monitor_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [15:0]      C_TIMEOUT  = 16'(TIMEOUT);
   localparam logic [15:0]      C_IDLE_ONE = 16'd1;
   localparam logic [GAP_W-1:0] C_GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] r_ntrig;
   logic [GAP_W-1:0] r_gap;
   logic [GAP_W-1:0] r_ic;
   logic [15:0]      r_idle;
   logic [CNT_W-1:0] r_seen;
   logic [CNT_W-1:0] r_gap_err;
   logic [GAP_W-1:0] r_last_gap;
   logic             r_err;
   logic             r_timeout;
   logic             r_overrun;

   logic             w_arm;       // IDLE -> ARMED this cycle
   logic             w_take;      // trigger accepted and counted
   logic             w_first;     // accepted trigger is the first since arm
   logic             w_tmo;       // idle limit reached with no trigger
   logic             w_ovr;       // trigger arrived after completion
   logic [15:0]      w_idle_inc;
   logic [CNT_W-1:0] w_seen_inc;
   logic [GAP_W-1:0] w_interval;
   logic             w_gap_bad;

   assign w_idle_inc = r_idle + C_IDLE_ONE;
   assign w_seen_inc = r_seen + C_CNT_ONE;
   // Interval counts the trigger cycle itself, clamped at the field maximum
   assign w_interval = (r_ic == '1) ? r_ic : r_ic + C_GAP_ONE;
   assign w_gap_bad  = (r_gap != '0) && (w_interval != r_gap);
   assign w_first    = (r_state == S_ARMED);

   // State register plus registered busy/done decoded from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_RUN);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

   // Next-state and per-cycle event strobes; abort outranks trigger outranks timeout
   always_comb begin
      w_state_nxt = r_state;
      w_arm       = 1'b0;
      w_take      = 1'b0;
      w_tmo       = 1'b0;
      w_ovr       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.ene) begin
               w_arm       = 1'b1;
               w_state_nxt = S_ARMED;
            end
         end
         S_ARMED, S_RUN: begin
            if (!bus.ene) begin
               w_state_nxt = S_IDLE;
            end else if ((r_state == S_ARMED) && (r_ntrig == '0)) begin
               w_state_nxt = S_DONE;
            end else if (bus.trigger) begin
               w_take      = 1'b1;
               w_state_nxt = (w_seen_inc == r_ntrig) ? S_DONE : S_RUN;
            end else if (w_idle_inc == C_TIMEOUT) begin
               w_tmo       = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (!bus.ene) begin
               w_state_nxt = S_IDLE;
            end else if (bus.trigger) begin
               w_ovr = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Capture at arm, count triggers, measure intervals, latch sticky status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ntrig    <= '0;
         r_gap      <= '0;
         r_ic       <= '0;
         r_idle     <= '0;
         r_seen     <= '0;
         r_gap_err  <= '0;
         r_last_gap <= '0;
         r_err      <= 1'b0;
         r_timeout  <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (w_arm) begin
         r_ntrig    <= bus.ntrig;
         r_gap      <= bus.gap;
         r_ic       <= '0;
         r_idle     <= '0;
         r_seen     <= '0;
         r_gap_err  <= '0;
         r_last_gap <= '0;
         r_err      <= 1'b0;
         r_timeout  <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (r_state == S_ARMED || r_state == S_RUN) begin
            r_idle <= w_take ? '0 : w_idle_inc;
         end
         if (w_take) begin
            r_seen <= w_seen_inc;
            r_ic   <= '0;
            if (!w_first) begin
               r_last_gap <= w_interval;
               if (w_gap_bad) begin
                  r_err <= 1'b1;
                  if (r_gap_err != '1) begin
                     r_gap_err <= r_gap_err + C_CNT_ONE;
                  end
               end
            end
         end else if (r_state == S_RUN && r_ic != '1) begin
            r_ic <= r_ic + C_GAP_ONE;
         end
         if (w_tmo) begin
            r_timeout <= 1'b1;
         end
         if (w_ovr) begin
            r_overrun <= 1'b1;
         end
      end
   end

`ifdef TRIG_HIST_EN
   logic [GAP_W-1:0] r_min_gap;
   logic [GAP_W-1:0] r_max_gap;

   // Interval extremes since arm, first trigger excluded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_min_gap <= '1;
         r_max_gap <= '0;
      end else if (w_arm) begin
         r_min_gap <= '1;
         r_max_gap <= '0;
      end else if (w_take && !w_first) begin
         if (w_interval < r_min_gap) begin
            r_min_gap <= w_interval;
         end
         if (w_interval > r_max_gap) begin
            r_max_gap <= w_interval;
         end
      end
   end

   assign bus.min_gap = r_min_gap;
   assign bus.max_gap = r_max_gap;
`else
   assign bus.min_gap = '0;
   assign bus.max_gap = '0;
`endif

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.ntrig_seen  = r_seen;
   assign bus.gap_err_cnt = r_gap_err;
   assign bus.last_gap    = r_last_gap;
   assign bus.err         = r_err;
   assign bus.timeout     = r_timeout;
   assign bus.overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_trig_monitor.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_trig_monitor                                            |
// | Description : Directed self-checking bench for trig_monitor.             |
// |               Honours TRIG_HIST_EN for min/max expectations.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_trig_monitor;

   localparam int GAP_W   = 8;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 1000;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   trig_monitor_if #(.GAP_W(GAP_W), .CNT_W(CNT_W)) mon ();

   trig_monitor #(
      .GAP_W   (GAP_W),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (mon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; outputs are then stable for sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic fire();
      mon.trigger = 1'b1;
      tick();
      mon.trigger = 1'b0;
   endtask

   task automatic arm(input int n, input int g);
      mon.ntrig = CNT_W'(n);
      mon.gap   = GAP_W'(g);
      mon.ene   = 1'b1;
      tick();
   endtask

   task automatic disarm();
      mon.ene = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      checks++; if (mon.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", mon.busy); end
      checks++; if (mon.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", mon.done); end
      checks++; if (mon.ntrig_seen !== 16'd0) begin failures++; $display("FAIL rst_seen got=%0d exp=0", mon.ntrig_seen); end
      checks++; if (mon.gap_err_cnt !== 16'd0) begin failures++; $display("FAIL rst_gaperr got=%0d exp=0", mon.gap_err_cnt); end
      checks++; if (mon.last_gap !== 8'd0) begin failures++; $display("FAIL rst_lastgap got=%0d exp=0", mon.last_gap); end
      checks++; if ({mon.err, mon.timeout, mon.overrun} !== 3'b000) begin failures++; $display("FAIL rst_sticky got=%b exp=000", {mon.err, mon.timeout, mon.overrun}); end
`ifdef TRIG_HIST_EN
      checks++; if (mon.min_gap !== 8'hFF) begin failures++; $display("FAIL rst_min got=%0d exp=255", mon.min_gap); end
`else
      checks++; if (mon.min_gap !== 8'h00) begin failures++; $display("FAIL rst_min got=%0d exp=0", mon.min_gap); end
`endif
      checks++; if (mon.max_gap !== 8'h00) begin failures++; $display("FAIL rst_max got=%0d exp=0", mon.max_gap); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_nominal();
      arm(5, 4);
      checks++; if (mon.busy !== 1'b1) begin failures++; $display("FAIL nom_busy_arm got=%0b exp=1", mon.busy); end
      // Inputs changed after arm must be ignored
      mon.ntrig = 16'd1;
      mon.gap   = 8'd7;
      fire();
      repeat (4) begin
         idle(3);
         fire();
      end
      checks++; if (mon.done !== 1'b1) begin failures++; $display("FAIL nom_done got=%0b exp=1", mon.done); end
      checks++; if (mon.busy !== 1'b0) begin failures++; $display("FAIL nom_busy got=%0b exp=0", mon.busy); end
      checks++; if (mon.ntrig_seen !== 16'd5) begin failures++; $display("FAIL nom_seen got=%0d exp=5", mon.ntrig_seen); end
      checks++; if (mon.gap_err_cnt !== 16'd0) begin failures++; $display("FAIL nom_gaperr got=%0d exp=0", mon.gap_err_cnt); end
      checks++; if (mon.err !== 1'b0) begin failures++; $display("FAIL nom_err got=%0b exp=0", mon.err); end
      checks++; if (mon.last_gap !== 8'd4) begin failures++; $display("FAIL nom_lastgap got=%0d exp=4", mon.last_gap); end
      disarm();
      checks++; if (mon.done !== 1'b0) begin failures++; $display("FAIL nom_done_release got=%0b exp=0", mon.done); end
      checks++; if (mon.ntrig_seen !== 16'd5) begin failures++; $display("FAIL nom_seen_held got=%0d exp=5", mon.ntrig_seen); end
   endtask

   task automatic test_gap_err();
      arm(4, 4);
      checks++; if (mon.ntrig_seen !== 16'd0) begin failures++; $display("FAIL gap_seen_clear got=%0d exp=0", mon.ntrig_seen); end
      fire();
      idle(3); fire();   // interval 4
      idle(5); fire();   // interval 6
      idle(3); fire();   // interval 4
      checks++; if (mon.gap_err_cnt !== 16'd1) begin failures++; $display("FAIL gap_gaperr got=%0d exp=1", mon.gap_err_cnt); end
      checks++; if (mon.err !== 1'b1) begin failures++; $display("FAIL gap_err got=%0b exp=1", mon.err); end
      checks++; if (mon.last_gap !== 8'd4) begin failures++; $display("FAIL gap_lastgap got=%0d exp=4", mon.last_gap); end
      checks++; if (mon.done !== 1'b1) begin failures++; $display("FAIL gap_done got=%0b exp=1", mon.done); end
`ifdef TRIG_HIST_EN
      checks++; if (mon.min_gap !== 8'd4) begin failures++; $display("FAIL gap_min got=%0d exp=4", mon.min_gap); end
      checks++; if (mon.max_gap !== 8'd6) begin failures++; $display("FAIL gap_max got=%0d exp=6", mon.max_gap); end
`else
      checks++; if (mon.min_gap !== 8'd0) begin failures++; $display("FAIL gap_min got=%0d exp=0", mon.min_gap); end
      checks++; if (mon.max_gap !== 8'd0) begin failures++; $display("FAIL gap_max got=%0d exp=0", mon.max_gap); end
`endif
      disarm();
   endtask

   task automatic test_timeout();
      int k;
      arm(3, 2);
      checks++; if (mon.err !== 1'b0) begin failures++; $display("FAIL tmo_err_clear got=%0b exp=0", mon.err); end
      fire();
      k = 0;
      while (mon.done !== 1'b1 && k < TIMEOUT + 100) begin
         tick();
         k++;
      end
      checks++; if (k !== TIMEOUT) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", k, TIMEOUT); end
      checks++; if (mon.timeout !== 1'b1) begin failures++; $display("FAIL tmo_flag got=%0b exp=1", mon.timeout); end
      checks++; if (mon.ntrig_seen !== 16'd1) begin failures++; $display("FAIL tmo_seen got=%0d exp=1", mon.ntrig_seen); end
      disarm();
   endtask

   task automatic test_overrun();
      arm(2, 3);
      checks++; if (mon.timeout !== 1'b0) begin failures++; $display("FAIL ovr_tmo_clear got=%0b exp=0", mon.timeout); end
      fire();
      idle(2); fire();
      checks++; if (mon.done !== 1'b1) begin failures++; $display("FAIL ovr_done got=%0b exp=1", mon.done); end
      checks++; if (mon.overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%0b exp=0", mon.overrun); end
      idle(2); fire();
      idle(2); fire();
      checks++; if (mon.overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%0b exp=1", mon.overrun); end
      checks++; if (mon.ntrig_seen !== 16'd2) begin failures++; $display("FAIL ovr_seen got=%0d exp=2", mon.ntrig_seen); end
      checks++; if (mon.done !== 1'b1) begin failures++; $display("FAIL ovr_done_held got=%0b exp=1", mon.done); end
      disarm();
   endtask

   task automatic test_zero_ntrig();
      arm(0, 0);
      checks++; if (mon.done !== 1'b0) begin failures++; $display("FAIL zero_done_early got=%0b exp=0", mon.done); end
      tick();
      checks++; if (mon.done !== 1'b1) begin failures++; $display("FAIL zero_done got=%0b exp=1", mon.done); end
      checks++; if (mon.ntrig_seen !== 16'd0) begin failures++; $display("FAIL zero_seen got=%0d exp=0", mon.ntrig_seen); end
      checks++; if (mon.overrun !== 1'b0) begin failures++; $display("FAIL zero_ovr_clear got=%0b exp=0", mon.overrun); end
      disarm();
   endtask

   task automatic test_back_to_back();
      arm(10, 0);
      fire();
      fire();            // interval 1
      checks++; if (mon.last_gap !== 8'd1) begin failures++; $display("FAIL b2b_lastgap got=%0d exp=1", mon.last_gap); end
      checks++; if (mon.ntrig_seen !== 16'd2) begin failures++; $display("FAIL b2b_seen got=%0d exp=2", mon.ntrig_seen); end
      idle(6); fire();   // interval 7
      checks++; if (mon.last_gap !== 8'd7) begin failures++; $display("FAIL b2b_lastgap7 got=%0d exp=7", mon.last_gap); end
      idle(299); fire(); // interval 300 clamps to 255
      checks++; if (mon.last_gap !== 8'd255) begin failures++; $display("FAIL b2b_lastgap_sat got=%0d exp=255", mon.last_gap); end
      checks++; if (mon.err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%0b exp=0", mon.err); end
      checks++; if (mon.gap_err_cnt !== 16'd0) begin failures++; $display("FAIL b2b_gaperr got=%0d exp=0", mon.gap_err_cnt); end
`ifdef TRIG_HIST_EN
      checks++; if (mon.min_gap !== 8'd1) begin failures++; $display("FAIL b2b_min got=%0d exp=1", mon.min_gap); end
      checks++; if (mon.max_gap !== 8'd255) begin failures++; $display("FAIL b2b_max got=%0d exp=255", mon.max_gap); end
`endif
      checks++; if (mon.busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0b exp=1", mon.busy); end
      disarm();
      checks++; if (mon.done !== 1'b0) begin failures++; $display("FAIL b2b_abort_done got=%0b exp=0", mon.done); end
   endtask

   task automatic test_rst_mid_run();
      arm(10, 3);
      fire();
      idle(2); fire();
      idle(2); fire();
      checks++; if (mon.ntrig_seen !== 16'd3) begin failures++; $display("FAIL rmr_seen_pre got=%0d exp=3", mon.ntrig_seen); end
      #2 rst = 1'b1;
      #1;
      checks++; if (mon.busy !== 1'b0) begin failures++; $display("FAIL rmr_busy got=%0b exp=0", mon.busy); end
      checks++; if (mon.ntrig_seen !== 16'd0) begin failures++; $display("FAIL rmr_seen got=%0d exp=0", mon.ntrig_seen); end
      checks++; if (mon.last_gap !== 8'd0) begin failures++; $display("FAIL rmr_lastgap got=%0d exp=0", mon.last_gap); end
      mon.ene = 1'b0;
      #1 rst = 1'b0;
      tick();
      checks++; if (mon.busy !== 1'b0) begin failures++; $display("FAIL rmr_busy_after got=%0b exp=0", mon.busy); end
   endtask

   task automatic test_abort();
      arm(10, 3);
      fire();
      idle(2); fire();
      mon.ene     = 1'b0;
      mon.trigger = 1'b1;  // trigger on the abort cycle is dropped
      tick();
      mon.trigger = 1'b0;
      checks++; if (mon.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", mon.busy); end
      checks++; if (mon.ntrig_seen !== 16'd2) begin failures++; $display("FAIL abort_seen got=%0d exp=2", mon.ntrig_seen); end
      idle(3);
      checks++; if (mon.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%0b exp=0", mon.done); end
      checks++; if (mon.ntrig_seen !== 16'd2) begin failures++; $display("FAIL abort_seen_held got=%0d exp=2", mon.ntrig_seen); end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      mon.ene     = 1'b0;
      mon.ntrig   = '0;
      mon.gap     = '0;
      mon.trigger = 1'b0;
      test_reset();
      test_nominal();
      test_gap_err();
      test_timeout();
      test_overrun();
      test_zero_ntrig();
      test_back_to_back();
      test_rst_mid_run();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/trig_monitor.md
# trig_monitor

Trigger-stream monitor for the CDT test path: the receiving end of the periodic trigger generator. It samples a single-clock trigger line and counts pulses against an expected total. It measures the interval between consecutive pulses, checks each interval against the expected gap, and reports completion, gap errors, timeout and overrun as registered status.

## Interface
- GAP_W, 8: width of gap and interval fields
- CNT_W, 16: width of trigger count and error count
- TIMEOUT, 1000: cycles without a trigger (while ARMED/RUN) before abort-with-timeout; must be < 2^16
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- ene  input  1  level enable; arms monitor on rising into ARMED, abort/release when low
- ntrig  input  CNT_W  expected number of triggers, captured at arm
- gap  input  GAP_W  expected interval in clk cycles, captured at arm; 0 = no interval check
- trigger  input  1  trigger line, each high cycle is one trigger
- busy  output  1  high in ARMED or RUN
- done  output  1  high in DONE
- ntrig_seen  output  CNT_W  triggers counted since arm
- gap_err_cnt  output  CNT_W  intervals not equal to captured gap, saturating
- last_gap  output  GAP_W  most recent measured interval
- err  output  1  sticky: any gap error since arm
- timeout  output  1  sticky: run ended by TIMEOUT
- overrun  output  1  sticky: trigger seen in DONE while ene high
- min_gap, max_gap  output  GAP_W  interval extremes (see Configuration)

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset -> IDLE; all outputs 0; min_gap reset to all-ones when compiled in.
- IDLE, ene=1: capture ntrig/gap into internal regs. Clear ntrig_seen, gap_err_cnt, last_gap, err, timeout, overrun, min/max. -> ARMED. A trigger on this same cycle is ignored.
- ARMED: if captured ntrig=0 -> DONE next cycle. On trigger: ntrig_seen=1, interval counter ic=0, -> RUN, or -> DONE if captured ntrig=1. No interval check on the first trigger.
- RUN, non-trigger cycle: ic increments, saturating at 2^GAP_W-1.
- RUN, trigger cycle: interval = min(ic+1, 2^GAP_W-1) -> last_gap. If gap!=0 and interval!=gap: gap_err_cnt++ (saturating at all-ones) and err=1. ntrig_seen++. ic=0. If new ntrig_seen == captured ntrig -> DONE.
- Timeout: a 16-bit idle counter clears on every trigger and on arm, and increments in ARMED/RUN. When it reaches TIMEOUT, set timeout=1 and go -> DONE; a trigger on that same cycle wins, is processed normally, and the counter clears.
- DONE: results held. A trigger with ene=1 sets overrun and is not counted. ene=0 -> IDLE.
- ene=0 in ARMED/RUN: abort -> IDLE next cycle. done never asserts; counters hold their values. A trigger on the abort cycle is not counted.
- Status is held in IDLE until the next arm.

## Timing
- All outputs registered; trigger sampled at clk edge N shows in ntrig_seen/last_gap/err after edge N.
- done/busy change one cycle after the deciding trigger, ene edge or timeout.
- Triggers at cycles 10 and 13 -> interval 3. Back-to-back high cycles -> interval 1, two triggers.
- Max trigger rate: one per cycle, no drops.
- ntrig/gap changes after arm have no effect until the next arm.
- rst is asynchronous at any state, including mid-RUN: immediate return to IDLE with reset values.

## Configuration
- TRIG_HIST_EN defined: min_gap/max_gap track the smallest and largest measured interval since arm (first trigger excluded). Reset/arm values are min=all-ones, max=0.
- TRIG_HIST_EN undefined: min/max logic is not built; min_gap and max_gap are tied to 0.

## Test plan
- ntrig=5, gap=4, triggers every 4 cycles -> done after 5th trigger, ntrig_seen=5, gap_err_cnt=0, err=0, last_gap=4.
- ntrig=4, gap=4, intervals 4,6,4 -> gap_err_cnt=1, err=1, last_gap=4, done=1; with TRIG_HIST_EN min_gap=4, max_gap=6.
- ntrig=3, gap=2, one trigger then silence -> timeout=1 and done exactly TIMEOUT cycles after the trigger, ntrig_seen=1.
- ntrig=2, gap=3, 4 triggers, ene held -> done after 2nd trigger, overrun=1, ntrig_seen stays 2.
- ntrig=0 -> done one cycle after ARMED, ntrig_seen=0. gap=0, intervals 1,7,300 -> err=0, last_gap=255.
- rst pulse mid-RUN (ntrig_seen=3) -> all outputs 0 immediately, busy=0. ene dropped mid-RUN -> IDLE, done stays 0, ntrig_seen held.
